// File: rtl/csi_rx_clk_mon.sv
`default_nettype none
// ============================================================================
// csi_rx_clk_mon -- multi-channel clock monitor: alive flag, edge count, lock
// Revision 1.0
// ============================================================================
module csi_rx_clk_mon #(
    parameter int N_CH      = 2,
    parameter int TIMEOUT   = 10,
    parameter int WIN_LEN   = 256,
    parameter int CNT_W     = 10,
    parameter int MIN_EDGES = 100,
    parameter int MAX_EDGES = 200,
    parameter int LOCK_WINS = 4
) (
    input  logic                  ref_clock,
    input  logic                  reset_in,
    input  logic                  enable,
    input  logic [N_CH-1:0]       clk_in,
    output logic [N_CH-1:0]       clk_alive,
    output logic [N_CH-1:0]       clk_locked,
    output logic                  meas_valid,
    output logic [N_CH*CNT_W-1:0] meas_count,
    output logic                  any_fail
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int WW = $clog2(WIN_LEN);
    localparam int GW = $clog2(LOCK_WINS + 1);

    localparam logic [TW-1:0]    TO_MAX    = TW'(TIMEOUT);
    localparam logic [WW-1:0]    WIN_LAST  = WW'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] EDGE_MAX  = '1;
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_EDGES);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_EDGES);
    localparam logic [GW-1:0]    LOCK_C    = GW'(LOCK_WINS);

    localparam logic [1:0] UNLOCKED = 2'd0;
    localparam logic [1:0] ACQUIRE  = 2'd1;
    localparam logic [1:0] LOCKED   = 2'd2;

    logic          en_q;
    logic          win_active;
    logic          win_close;
    logic [WW-1:0] win_cnt;

    // The first enabled cycle only arms the window; counting starts the cycle after.
    assign win_active = enable & en_q;
    assign win_close  = win_active && (win_cnt == WIN_LAST);

    always_ff @(posedge ref_clock) begin
        if (reset_in) begin
            en_q       <= 1'b0;
            win_cnt    <= '0;
            meas_valid <= 1'b0;
        end else begin
            en_q       <= enable;
            meas_valid <= win_close;
            if (!win_active || win_close)
                win_cnt <= '0;
            else
                win_cnt <= win_cnt + 1'b1;
        end
    end

    assign any_fail = |(~clk_alive);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic             s0, s1, prev;
        logic             toggle, rise;
        logic [TW-1:0]    to_cnt;
        logic             alive;
        logic [CNT_W-1:0] edge_cnt, edge_next, meas_q;
        logic             dead, dead_final, good;
        logic [1:0]       state, state_next;
        logic [GW-1:0]    good_cnt, good_next;
        logic             locked;

        assign toggle = s1 ^ prev;
        assign rise   = s1 & ~prev;

        always_ff @(posedge ref_clock) begin
            if (reset_in) begin
                s0     <= 1'b0;
                s1     <= 1'b0;
                prev   <= 1'b0;
                to_cnt <= TO_MAX;
                alive  <= 1'b0;
            end else begin
                s0    <= clk_in[i];
                s1    <= s0;
                prev  <= s1;
                alive <= (to_cnt < TO_MAX);
                if (toggle)
                    to_cnt <= '0;
                else if (to_cnt != TO_MAX)
                    to_cnt <= to_cnt + 1'b1;
            end
        end

        // Window result includes a rise or a dead cycle landing on the close cycle itself.
        assign edge_next  = (rise && (edge_cnt != EDGE_MAX)) ? edge_cnt + 1'b1 : edge_cnt;
        assign dead_final = dead | ~alive;
        assign good       = !dead_final && (edge_next >= MIN_C) && (edge_next <= MAX_C);

        always_ff @(posedge ref_clock) begin
            if (reset_in) begin
                edge_cnt <= '0;
                dead     <= 1'b0;
                meas_q   <= '0;
            end else begin
                if (win_close)
                    meas_q <= edge_next;
                if (!win_active || win_close) begin
                    edge_cnt <= '0;
                    dead     <= 1'b0;
                end else begin
                    edge_cnt <= edge_next;
                    dead     <= dead_final;
                end
            end
        end

        always_ff @(posedge ref_clock) begin
            if (reset_in) begin
                state    <= UNLOCKED;
                good_cnt <= '0;
            end else begin
                state    <= state_next;
                good_cnt <= good_next;
            end
        end

        always_comb begin
            state_next = state;
            good_next  = good_cnt;
            if (!enable) begin
                state_next = UNLOCKED;
                good_next  = '0;
            end else if ((state == LOCKED) && !alive) begin
                state_next = UNLOCKED;
                good_next  = '0;
            end else if (win_close) begin
                case (state)
                    UNLOCKED: begin
                        if (good) begin
                            good_next  = GW'(1);
                            state_next = (LOCK_C == GW'(1)) ? LOCKED : ACQUIRE;
                        end
                    end
                    ACQUIRE: begin
                        if (good) begin
                            good_next = good_cnt + 1'b1;
                            if ((good_cnt + 1'b1) == LOCK_C)
                                state_next = LOCKED;
                        end else begin
                            state_next = UNLOCKED;
                            good_next  = '0;
                        end
                    end
                    LOCKED: begin
                        if (!good) begin
                            state_next = UNLOCKED;
                            good_next  = '0;
                        end
                    end
                    default: begin
                        state_next = UNLOCKED;
                        good_next  = '0;
                    end
                endcase
            end
        end

        always_comb begin
            locked = (state == LOCKED);
        end

        assign clk_alive[i]                   = alive;
        assign clk_locked[i]                  = locked;
        assign meas_count[i*CNT_W +: CNT_W]   = meas_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_csi_rx_clk_mon.sv
`default_nettype none
// ============================================================================
// tb_csi_rx_clk_mon -- directed bench for csi_rx_clk_mon (alive, count, lock)
// Revision 1.0
// ============================================================================
module tb_csi_rx_clk_mon;

    localparam int N_CH      = 2;
    localparam int TIMEOUT   = 10;
    localparam int WIN_LEN   = 64;
    localparam int CNT_W     = 6;
    localparam int MIN_EDGES = 6;
    localparam int MAX_EDGES = 10;
    localparam int LOCK_WINS = 3;

    logic                  ref_clock = 1'b0;
    logic                  reset_in;
    logic                  enable;
    logic [N_CH-1:0]       clk_in;
    logic [N_CH-1:0]       clk_alive;
    logic [N_CH-1:0]       clk_locked;
    logic                  meas_valid;
    logic [N_CH*CNT_W-1:0] meas_count;
    logic                  any_fail;

    logic [CNT_W-1:0] mc0, mc1;
    assign mc0 = meas_count[0 +: CNT_W];
    assign mc1 = meas_count[CNT_W +: CNT_W];

    int checks   = 0;
    int failures = 0;
    int mv_seen  = 0;
    int half [2] = '{0, 0};
    int ph   [2] = '{0, 0};

    csi_rx_clk_mon #(
        .N_CH      (N_CH),
        .TIMEOUT   (TIMEOUT),
        .WIN_LEN   (WIN_LEN),
        .CNT_W     (CNT_W),
        .MIN_EDGES (MIN_EDGES),
        .MAX_EDGES (MAX_EDGES),
        .LOCK_WINS (LOCK_WINS)
    ) dut (
        .ref_clock  (ref_clock),
        .reset_in   (reset_in),
        .enable     (enable),
        .clk_in     (clk_in),
        .clk_alive  (clk_alive),
        .clk_locked (clk_locked),
        .meas_valid (meas_valid),
        .meas_count (meas_count),
        .any_fail   (any_fail)
    );

    always #5 ref_clock = ~ref_clock;

    // Monitored clocks: toggle every half[c] ref cycles, on the falling ref edge.
    initial begin
        forever begin
            @(negedge ref_clock);
            for (int c = 0; c < 2; c++) begin
                if (half[c] != 0) begin
                    ph[c]++;
                    if (ph[c] >= half[c]) begin
                        ph[c]     = 0;
                        clk_in[c] = ~clk_in[c];
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ref_clock);
        #1;
        if (meas_valid) mv_seen++;
    endtask

    task automatic wait_mv(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!meas_valid && n < 200);
        if (!meas_valid) check("mv_timeout", 32'(meas_valid), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_alive"},  32'(clk_alive),  32'd0);
        check({tag, "_locked"}, 32'(clk_locked), 32'd0);
        check({tag, "_mv"},     32'(meas_valid), 32'd0);
        check({tag, "_mc"},     32'(meas_count), 32'd0);
        check({tag, "_fail"},   32'(any_fail),   32'd1);
    endtask

    initial begin
        int n;
        int mvs;

        reset_in = 1'b1;
        enable   = 1'b0;
        clk_in   = '0;
        repeat (3) tick();
        check_reset_state("rst");

        // ch0 running before enable so the first window is already alive
        reset_in = 1'b0;
        half[0]  = 4;
        mvs      = mv_seen;
        repeat (20) tick();
        check("pre_alive", 32'(clk_alive), 32'd1);
        check("pre_fail",  32'(any_fail),  32'd1);
        check("pre_no_mv", 32'(mv_seen - mvs), 32'd0);

        enable = 1'b1;
        wait_mv(n);
        check("first_mv_lat", 32'(n), 32'd65);
        check("w1_mc0_8or9",  32'(mc0 >= 8 && mc0 <= 9), 32'd1);
        check("w1_mc1",       32'(mc1), 32'd0);
        check("w1_locked",    32'(clk_locked), 32'd0);
        tick();
        check("mv_pulse", 32'(meas_valid), 32'd0);
        wait_mv(n);
        check("mv_period", 32'(n + 1), 32'd64);
        check("w2_locked", 32'(clk_locked), 32'd0);
        wait_mv(n);
        check("w3_locked", 32'(clk_locked), 32'd1);
        check("w3_alive",  32'(clk_alive),  32'd1);
        check("w3_fail",   32'(any_fail),   32'd1);

        // ch1 starts too fast to be good
        half[1] = 2;
        n = 0;
        do begin
            tick();
            n++;
        end while (!clk_alive[1] && n < 30);
        check("ch1_alive_rise", 32'(n >= 4 && n <= 5), 32'd1);
        wait_mv(n);
        wait_mv(n);
        check("fast_mc1",    32'(mc1), 32'd16);
        check("fast_mc0",    32'(mc0), 32'd8);
        check("fast_locked", 32'(clk_locked), 32'd1);
        check("fast_alive",  32'(clk_alive),  32'd3);
        check("fast_fail",   32'(any_fail),   32'd0);

        // ch0 held low mid-window
        repeat (10) tick();
        n = 0;
        while (clk_in[0] == 1'b0 && n < 10) begin
            tick();
            n++;
        end
        half[0]   = 0;
        clk_in[0] = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (clk_alive[0] && n < 30);
        check("stop_alive_fall", 32'(n >= 13 && n <= 14), 32'd1);
        check("stop_fail",       32'(any_fail),   32'd1);
        check("stop_lock_hold",  32'(clk_locked), 32'd1);
        tick();
        check("stop_lock_fall",  32'(clk_locked), 32'd0);
        half[0] = 4;
        wait_mv(n);
        check("stop_win_lock", 32'(clk_locked), 32'd0);
        wait_mv(n);
        check("relock_w1", 32'(clk_locked), 32'd0);
        wait_mv(n);
        check("relock_w2", 32'(clk_locked), 32'd0);
        wait_mv(n);
        check("relock_w3", 32'(clk_locked), 32'd1);

        // one slow window (4 rises) drops lock
        half[0] = 8;
        wait_mv(n);
        check("slow_mc0_low", 32'(mc0 <= 5), 32'd1);
        check("slow_unlock",  32'(clk_locked), 32'd0);
        check("slow_alive",   32'(clk_alive),  32'd3);
        half[0] = 4;
        wait_mv(n);
        check("reacq_w1", 32'(clk_locked), 32'd0);
        wait_mv(n);
        check("reacq_w2", 32'(clk_locked), 32'd0);
        wait_mv(n);
        check("reacq_w3",  32'(clk_locked), 32'd1);
        check("reacq_mc0", 32'(mc0), 32'd8);

        // enable dropped for 20 cycles while locked
        repeat (10) tick();
        enable = 1'b0;
        mvs    = mv_seen;
        tick();
        check("dis_unlock", 32'(clk_locked), 32'd0);
        repeat (19) tick();
        check("dis_no_mv",   32'(mv_seen - mvs), 32'd0);
        check("dis_mc_hold", 32'(meas_count), 32'({6'd16, 6'd8}));
        check("dis_alive",   32'(clk_alive), 32'd3);
        enable = 1'b1;
        wait_mv(n);
        check("reen_mv_lat", 32'(n), 32'd65);

        // reset mid-window
        repeat (20) tick();
        reset_in = 1'b1;
        tick();
        check_reset_state("midrst");
        reset_in = 1'b0;
        mvs      = mv_seen;
        repeat (60) tick();
        check("midrst_no_mv", 32'(mv_seen - mvs), 32'd0);
        check("midrst_alive", 32'(clk_alive), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
